// File: rtl/dlatch_bank.sv
`default_nettype none
// ============================================================================
//  Module   : dlatch_bank
//  Purpose  : Bank of DEPTH clocked "gated latch" channels, WIDTH bits each.
//             A write (En) loads D into the shadow stage of channel Addr and
//             marks it dirty. A Commit copies every dirty shadow into its
//             active stage on the same edge, so several channels change
//             together. Q is a registered readout of active[Rd_addr], taken
//             from the post-commit value so a commit shows up one cycle later.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    WIDTH   data bits per channel (>= 1)
//    DEPTH   number of channels (>= 2, power of two)
//    ADDR_W  channel address width, must equal $clog2(DEPTH)
//  Ports
//    clk      in   1       rising-edge clock
//    rst_n    in   1       asynchronous active-low reset
//    En       in   1       load D into shadow[Addr] this edge
//    Addr     in   ADDR_W  write channel select
//    D        in   WIDTH   write data
//    Commit   in   1       copy every dirty shadow into active this edge
//    Rd_addr  in   ADDR_W  read channel select
//    Q        out  WIDTH   registered active[Rd_addr]
//    Dirty    out  DEPTH   bit i set while shadow[i] holds an uncommitted write
//    not_Q    out  WIDTH   registered ~Q (only with DLATCH_BANK_NOTQ_EN)
//  Configuration macro
//    DLATCH_BANK_NOTQ_EN  defined: not_Q port and its register are present
// ============================================================================
module dlatch_bank #(
   parameter int WIDTH  = 8,
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              En,
   input  logic [ADDR_W-1:0] Addr,
   input  logic [WIDTH-1:0]  D,
   input  logic              Commit,
   input  logic [ADDR_W-1:0] Rd_addr,
   output logic [WIDTH-1:0]  Q,
   output logic [DEPTH-1:0]  Dirty
`ifdef DLATCH_BANK_NOTQ_EN
   ,
   output logic [WIDTH-1:0]  not_Q
`else
`endif
);

   // ------------------------------------------------------------------------
   // Storage
   // ------------------------------------------------------------------------
   logic [WIDTH-1:0] shadow     [DEPTH];
   logic [WIDTH-1:0] active     [DEPTH];
   logic [DEPTH-1:0] dirty;

   logic [WIDTH-1:0] shadow_nxt [DEPTH];
   logic [WIDTH-1:0] active_nxt [DEPTH];
   logic [DEPTH-1:0] dirty_nxt;
   logic [DEPTH-1:0] wr_sel;

   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] q_nxt;

   // ------------------------------------------------------------------------
   // Per-channel next-state
   // ------------------------------------------------------------------------
   generate
      for (genvar i = 0; i < DEPTH; i++) begin : g_chan
         // Address decode for this channel.
         assign wr_sel[i] = En && (Addr == ADDR_W'(i));

         // Shadow takes D on a write regardless of Commit; on a
         // simultaneous write+commit this keeps shadow equal to active.
         assign shadow_nxt[i] = wr_sel[i] ? D : shadow[i];

         // On commit the freshly written value has priority over the old
         // shadow content (write-through); otherwise only dirty channels
         // are copied and clean ones keep their active value.
         always_comb begin
            active_nxt[i] = active[i];
            if (Commit) begin
               if (wr_sel[i]) begin
                  active_nxt[i] = D;
               end else if (dirty[i]) begin
                  active_nxt[i] = shadow[i];
               end
            end
         end
      end
   endgenerate

   // A commit clears every dirty bit, including a channel written on the
   // same edge, because that channel is written through to active.
   always_comb begin
      dirty_nxt = dirty;
      if (Commit) begin
         dirty_nxt = '0;
      end else begin
         dirty_nxt = dirty | wr_sel;
      end
   end

   // Readout uses the post-commit view so committed data reaches Q after
   // a single edge rather than two.
   assign q_nxt = active_nxt[Rd_addr];

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < DEPTH; k++) begin
            shadow[k] <= '0;
            active[k] <= '0;
         end
         dirty <= '0;
         q     <= '0;
      end else begin
         for (int k = 0; k < DEPTH; k++) begin
            shadow[k] <= shadow_nxt[k];
            active[k] <= active_nxt[k];
         end
         dirty <= dirty_nxt;
         q     <= q_nxt;
      end
   end

   assign Q     = q;
   assign Dirty = dirty;

`ifdef DLATCH_BANK_NOTQ_EN
   // Separate register loaded with the complement of the same next value,
   // so Q and not_Q always change on the same edge and reset to opposites.
   logic [WIDTH-1:0] not_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         not_q <= '1;
      end else begin
         not_q <= ~q_nxt;
      end
   end

   assign not_Q = not_q;
`else
   // Complementary readout not built in this configuration.
`endif

endmodule

`default_nettype wire

// File: doc/dlatch_bank.md
# dlatch_bank

Parametrised, clocked successor to the single-bit gated D latch: a bank of DEPTH storage channels, each WIDTH bits, with per-channel gated loading into a shadow stage and an atomic commit into the active stage. It replaces transparent latches with edge-triggered storage, so the gated-D behaviour is timing-clean. It adds multi-channel addressing, a dirty mask and a registered complementary readout. It sits between control/stimulus logic and any consumer that needs several gated values to change together.

## Interface
- WIDTH, 8, data bits per channel (≥1)
- DEPTH, 4, number of channels (≥2, power of two)
- ADDR_W, 2, channel address width, must equal log2(DEPTH)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- En  in  1  gate: load D into shadow[Addr] this edge
- Addr  in  ADDR_W  write channel select
- D  in  WIDTH  write data
- Commit  in  1  copy every dirty shadow into active this edge
- Rd_addr  in  ADDR_W  read channel select
- Q  out  WIDTH  registered active[Rd_addr]
- not_Q  out  WIDTH  bitwise complement of Q (present only with DLATCH_BANK_NOTQ_EN)
- Dirty  out  DEPTH  bit i set while shadow[i] holds an uncommitted write

## Operation
- Storage: shadow[0..DEPTH-1] and active[0..DEPTH-1], each WIDTH bits.
- En=1, Commit=0: shadow[Addr] <= D; Dirty[Addr] <= 1. Other channels hold.
- En=0, Commit=1: for each i with Dirty[i]=1, active[i] <= shadow[i]; Dirty <= 0. Clean channels hold.
- En=1, Commit=1 (simultaneous):
  - Channel Addr: active[Addr] <= D and shadow[Addr] <= D (write-through).
  - Other dirty channels commit normally.
  - Dirty <= 0.
- En=0, Commit=0: all storage holds. This is the latch "hold" state generalised.
- Repeated En to the same channel before Commit: last write wins. Dirty stays 1.
- Commit with Dirty=0: no-op and no error.
- Readout: Q <= active-next value of channel Rd_addr. not_Q is always ~Q.
- Out-of-range addresses cannot occur (DEPTH is a power of two).

## Timing
- Async reset (rst_n=0), effective immediately:
  - all shadow and active = 0
  - Dirty = 0
  - Q = 0
  - not_Q = all ones
- Release: rst_n deasserts synchronously by upstream convention. The first active edge after release may load.
- Reset asserted mid-sequence: pending shadow writes are discarded. No commit occurs.
- Write-to-Dirty latency: 1 cycle. Dirty[Addr] is visible after the En edge.
- Commit-to-Q latency: 1 cycle. Q reflects committed data after the Commit edge when Rd_addr selects that channel. The read mux uses post-commit values, so there is no extra cycle.
- Rd_addr change-to-Q latency: 1 cycle.
- Write-through (En and Commit together): D appears on Q 1 cycle later for the read channel.
- No combinational path from any input to Q, not_Q or Dirty.

## Configuration
- Macro: DLATCH_BANK_NOTQ_EN.
- Defined: the not_Q port exists and is registered as ~Q, so both outputs change on the same edge.
- Undefined: the not_Q port and its register are removed. All other behaviour is identical.

## Test plan
- Reset: hold rst_n=0 with En=1, D=8'hFF. Required: Q=8'h00, not_Q=8'hFF, Dirty=4'b0000. After release with En=0: outputs unchanged.
- Gated load, no commit: write D=8'hA5 to Addr=2, Rd_addr=2. Required: Dirty=4'b0100 and Q stays 8'h00. Then Commit=1: next cycle Q=8'hA5, not_Q=8'h5A, Dirty=0.
- Atomic multi-channel commit: write 8'h11 to ch0, 8'h22 to ch1 and 8'h33 to ch3, then Commit. Required: Dirty=4'b1011 before commit. After commit, sweeping Rd_addr 0,1,2,3 gives Q=11,22,00,33.
- Simultaneous En+Commit: ch1 is dirty with 8'h22. Apply En=1, Addr=2, D=8'h7E, Commit=1. Required: active1=8'h22, active2=8'h7E, Dirty=0.
- Last-write-wins and hold: write 8'h01 then 8'h02 to ch0, hold 3 idle cycles, then Commit. Required: Q(ch0)=8'h02 and Dirty[0]=1 throughout the idle cycles.
- Reset mid-operation: ch3 is dirty with 8'hC3. Assert rst_n=0 for 1 cycle, then Commit. Required: Q(ch3)=8'h00 and Dirty=0.
